// File: rtl/second_tick_qualifier.sv
// Per-channel a&~b qualifier: fires after HOLD consecutive qualifying edges,
// with level/pulse output and a saturating count of fire events.
module second_tick_qualifier #(
    parameter int CHANNELS = 4,
    parameter int HOLD     = 2,
    parameter int EVT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                clr,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    output logic [CHANNELS-1:0] out,
    output logic                any_out,
    output logic [EVT_W-1:0]    evt_cnt
);

    localparam int CW = $clog2(HOLD + 1);
    localparam int SW = EVT_W + 5;
    localparam logic [CW-1:0]    HOLD_C = CW'(HOLD);
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, COUNT, FIRED} state_t;

    state_t         st     [CHANNELS];
    state_t         st_nx  [CHANNELS];
    logic [CW-1:0]  cnt    [CHANNELS];
    logic [CW-1:0]  cnt_nx [CHANNELS];
    logic [CW-1:0]  cnt_inc;
    logic [CHANNELS-1:0] cond;
    logic [CHANNELS-1:0] fire;
    logic [CHANNELS-1:0] out_nx;
    logic [4:0]          nfire;
    logic [SW-1:0]       evt_sum;
    logic [EVT_W-1:0]    evt_nx;

    assign cond = a & ~b;

    always_comb begin
        cnt_inc = '0;
        nfire   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            st_nx[i]  = IDLE;
            cnt_nx[i] = '0;
            fire[i]   = 1'b0;
            if (en && cond[i]) begin
                unique case (st[i])
                    IDLE: begin
                        cnt_nx[i] = CW'(1);
                        if (HOLD == 1) begin
                            st_nx[i] = FIRED;
                            fire[i]  = 1'b1;
                        end else begin
                            st_nx[i] = COUNT;
                        end
                    end
                    COUNT: begin
                        cnt_inc   = cnt[i] + CW'(1);
                        cnt_nx[i] = cnt_inc;
                        if (cnt_inc == HOLD_C) begin
                            st_nx[i] = FIRED;
                            fire[i]  = 1'b1;
                        end else begin
                            st_nx[i] = COUNT;
                        end
                    end
                    FIRED: begin
                        st_nx[i]  = FIRED;
                        cnt_nx[i] = HOLD_C;
                    end
                    default: begin
                        st_nx[i]  = IDLE;
                        cnt_nx[i] = '0;
                    end
                endcase
            end
            // Pulse mode only shows the entry edge; a later mode flip
            // to pulse therefore drops out without a fresh pulse.
            out_nx[i] = (st_nx[i] == FIRED) && (!mode || fire[i]);
            nfire = nfire + 5'(fire[i]);
        end
        evt_sum = SW'(evt_cnt) + SW'(nfire);
        evt_nx  = (evt_sum > SW'(EVT_MAX)) ? EVT_MAX : evt_sum[EVT_W-1:0];
        if (clr) begin
            evt_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
            out     <= '0;
            any_out <= 1'b0;
            evt_cnt <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]  <= st_nx[i];
                cnt[i] <= cnt_nx[i];
            end
            out     <= out_nx;
            any_out <= |out_nx;
            evt_cnt <= evt_nx;
        end
    end

endmodule

// File: tb/tb_second_tick_qualifier.sv
// Directed bench for second_tick_qualifier at CHANNELS=4, HOLD=2, EVT_W=8.
module tb_second_tick_qualifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       any_out;
    logic [7:0] evt_cnt;

    int errs   = 0;
    int checks = 0;

    second_tick_qualifier #(
        .CHANNELS(4),
        .HOLD(2),
        .EVT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .clr(clr),
        .a(a),
        .b(b),
        .out(out),
        .any_out(any_out),
        .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [3:0] eo,
                        input logic [7:0] ee);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".any"}, 32'(any_out), 32'(|eo));
        chk({tag, ".evt"}, 32'(evt_cnt), 32'(ee));
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        mode = 1'b0;
        clr = 1'b0;
        a = 4'h0;
        b = 4'h0;
        #2;
        chk3("reset", 4'h0, 8'd0);
        tick();
        rst = 1'b0;

        // level mode, single channel
        en = 1'b1;
        a = 4'b0001;
        tick(); chk3("lvl.e1", 4'h0, 8'd0);
        tick(); chk3("lvl.e2", 4'h1, 8'd1);
        tick(); chk3("lvl.e3", 4'h1, 8'd1);
        tick(); chk3("lvl.e4", 4'h1, 8'd1);
        a = 4'h0;
        tick(); chk3("lvl.drop", 4'h0, 8'd1);

        // pulse mode, then mode flips while fired
        mode = 1'b1;
        a = 4'b0001;
        tick(); chk3("pul.e1", 4'h0, 8'd1);
        tick(); chk3("pul.e2", 4'h1, 8'd2);
        tick(); chk3("pul.e3", 4'h0, 8'd2);
        tick(); chk3("pul.e4", 4'h0, 8'd2);
        mode = 1'b0;
        tick(); chk3("mode10", 4'h1, 8'd2);
        mode = 1'b1;
        tick(); chk3("mode01", 4'h0, 8'd2);
        a = 4'h0;
        tick(); chk3("pul.drop", 4'h0, 8'd2);

        // interrupted qualification restarts
        mode = 1'b0;
        a = 4'b0001;
        tick(); chk3("int.e1", 4'h0, 8'd2);
        b = 4'b0001;
        tick(); chk3("int.e2", 4'h0, 8'd2);
        b = 4'h0;
        tick(); chk3("int.e3", 4'h0, 8'd2);
        tick(); chk3("int.e4", 4'h1, 8'd3);
        a = 4'h0;
        clr = 1'b1;
        tick(); chk3("clr", 4'h0, 8'd0);
        clr = 1'b0;

        // all channels fire together
        a = 4'hF;
        tick(); chk3("all.e1", 4'h0, 8'd0);
        tick(); chk3("all.e2", 4'hF, 8'd4);
        a = 4'h0;
        tick(); chk3("all.drop", 4'h0, 8'd4);
        a = 4'hF;
        tick(); chk3("clrf.e1", 4'h0, 8'd4);
        clr = 1'b1;
        tick(); chk3("clrf.e2", 4'hF, 8'd0);
        clr = 1'b0;
        a = 4'h0;
        tick();

        // global disable mid-count
        a = 4'hF;
        tick(); chk3("en.e1", 4'h0, 8'd0);
        en = 1'b0;
        tick(); chk3("en.off", 4'h0, 8'd0);
        tick(); chk3("en.off2", 4'h0, 8'd0);
        en = 1'b1;
        tick(); chk3("en.on1", 4'h0, 8'd0);
        tick(); chk3("en.on2", 4'hF, 8'd4);
        a = 4'h0;
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // saturation: 63 rounds of 4 fires, then 2, then 4 more
        for (int r = 0; r < 63; r++) begin
            a = 4'hF;
            tick();
            tick();
            a = 4'h0;
            tick();
        end
        chk3("sat.252", 4'h0, 8'd252);
        a = 4'b0011;
        tick();
        tick(); chk3("sat.254", 4'h3, 8'd254);
        a = 4'h0;
        tick();
        a = 4'hF;
        tick();
        tick(); chk3("sat.255", 4'hF, 8'd255);
        a = 4'h0;
        tick();
        a = 4'hF;
        tick();
        tick(); chk3("sat.hold", 4'hF, 8'd255);

        // asynchronous reset while fired
        a = 4'h0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        a = 4'b0011;
        tick();
        tick(); chk3("ar.pre", 4'h3, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        chk3("ar.async", 4'h0, 8'd0);
        rst = 1'b0;
        tick(); chk3("ar.e1", 4'h0, 8'd0);
        tick(); chk3("ar.e2", 4'h3, 8'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/second_tick_qualifier.md
SECOND_TICK_QUALIFIER -- requirements
Module: second_tick_qualifier

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent a/b channels (1..16).
REQ-002 Parameter HOLD, default 2, consecutive qualifying cycles required before a channel fires (1..255).
REQ-003 Parameter EVT_W, default 8, width of the saturating event counter.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  1  global enable; 0 holds every channel idle.
REQ-007 Port mode  input  1  0 = level output, 1 = one-cycle pulse output.
REQ-008 Port clr  input  1  synchronous clear of the event counter.
REQ-009 Port a  input  CHANNELS  per-channel "a" operand.
REQ-010 Port b  input  CHANNELS  per-channel "b" operand.
REQ-011 Port out  output  CHANNELS  per-channel registered qualified output.
REQ-012 Port any_out  output  1  registered OR of the next-state out vector, equal to |out in the same cycle.
REQ-013 Port evt_cnt  output  EVT_W  number of fire events since reset/clr, saturating.

Function
REQ-014 Per-channel qualifying condition SHALL be cond[i] = a[i] AND NOT b[i], sampled at each rising clk edge.
REQ-015 Each channel SHALL run a 3-state FSM (IDLE, COUNT, FIRED) with a hold counter of width clog2(HOLD+1).
REQ-016 IDLE: on edge with en=1 and cond=1, counter := 1; go to FIRED if HOLD=1, else COUNT.
REQ-017 COUNT: on edge with en=1 and cond=1, counter += 1; on reaching HOLD, go to FIRED.
REQ-018 COUNT or FIRED: on edge with cond=0, counter := 0 and state := IDLE.
REQ-019 FIRED: remains FIRED while en=1 and cond=1; counter holds at HOLD (no wrap).
REQ-020 en=0 on any edge SHALL force all channels to IDLE, counters to 0, out to 0; no fire events are counted.
REQ-021 Latency: with cond held from edge 1, the channel enters FIRED, and out[i] rises, at edge HOLD (registered, no combinational path from a/b to out).
REQ-022 mode=0: out[i] = 1 exactly while the channel is in FIRED.
REQ-023 mode=1: out[i] = 1 only in the cycle after the IDLE/COUNT->FIRED transition, then 0 while FIRED persists.
REQ-024 A mode change while FIRED SHALL affect out from the next edge; switching 1->0 raises out, switching 0->1 drops out and issues no new pulse.
REQ-025 A fire event is an IDLE/COUNT->FIRED transition, independent of mode.
REQ-026 evt_cnt SHALL add the number of channels firing on that edge (0..CHANNELS) and saturate at 2^EVT_W-1, never wrapping.
REQ-027 clr=1 SHALL set evt_cnt to 0 on that edge; it takes priority over and discards same-edge events.
REQ-028 Channels SHALL be fully independent; simultaneous fires on several channels are all counted.

Reset
REQ-029 rst=1 SHALL immediately, without a clock, set all channels to IDLE, counters to 0, out to 0, any_out to 0, evt_cnt to 0.
REQ-030 Reset asserted mid-COUNT or mid-FIRED SHALL discard progress; after release, qualification restarts from IDLE.
REQ-031 The first edge after rst deasserts SHALL be treated as a normal sampling edge.

Verification (CHANNELS=4, HOLD=2, EVT_W=8)
REQ-032 mode=0, en=1, a=4'b0001, b=0 held 4 edges -> out[0] rises at edge 2 and stays 1; evt_cnt=1; other bits 0.
REQ-033 mode=1, same stimulus -> out[0]=1 only after edge 2, 0 after edges 3-4; evt_cnt=1.
REQ-034 ch0 cond=1 at edge 1, then b[0]=1 at edge 2, then cond=1 at edges 3-4 -> no out at edge 2, out[0] rises at edge 4; evt_cnt=1.
REQ-035 a=4'b1111, b=0 for 2 edges -> out=4'b1111 and evt_cnt=4 after edge 2; clr=1 at the firing edge -> evt_cnt=0.
REQ-036 Force evt_cnt to 254 via repeated fires, then fire 4 channels at once -> evt_cnt=255 and holds at 255 on further fires.
REQ-037 rst pulsed asynchronously between edges while out=4'b0011 -> out, any_out, evt_cnt read 0 before the next edge; cond held afterward -> refire at edge 2 after release.
